serv_load_unpacker: RTL and testbench
=====================================

// Module: serv_load_unpacker
// PURPOSE
//  Read-side counterpart of the address/shift buffer on the data bus: takes a load request whose
//  word address is already on the bus, runs the dbus read handshake, captures the 32-bit read word,
//  aligns it by the byte offset, and streams it back into the serial datapath BITS_PER_CYCLE bits
//  per cycle, LSB first, with sign or zero extension for LB/LBU/LH/LHU/LW.
// PARAMETERS
//  BITS_PER_CYCLE  8                        datapath width per beat; legal 1, 4, 8
//  LB              $clog2(BITS_PER_CYCLE)   derived, do not override
// PORTS
//  i_clk         in   1     clock, all state on posedge
//  i_rst         in   1     synchronous reset, active-high
//  i_req         in   1     load request pulse; o_dbus_adr from buffer register valid this cycle
//  i_lsb         in   2     byte offset of load address
//  i_size        in   2     0 = byte, 1 = half, 2 = word; 3 reserved, treated as word
//  i_signed      in   1     1 = sign-extend, 0 = zero-extend
//  o_dbus_cyc    out  1     bus cycle request, held until ack
//  i_dbus_ack    in   1     bus acknowledge, read data valid this cycle
//  i_dbus_rdat   in   32    bus read data
//  o_misalign    out  1     one-cycle pulse: request rejected, access crosses word
//  o_rdy         out  1     one-cycle pulse: data captured, streaming may start
//  i_en          in   1     stream advance: one beat per cycle while high
//  o_rd          out  BPC   current beat of aligned, extended load data
//  o_busy        out  1     high in any state except IDLE
// BEHAVIOUR
//  Reset: state IDLE, o_dbus_cyc=0, o_rdy=0, o_misalign=0, o_rd=0, beat counter=0, data reg=0.
//  FSM IDLE -> WAIT_ACK -> LOADED -> STREAM -> IDLE.
//   IDLE:     i_req with legal alignment -> WAIT_ACK; latch i_lsb/i_size/i_signed.
//             i_req with illegal alignment -> o_misalign=1 next cycle, stay IDLE, no bus cycle.
//             Illegal: half with i_lsb=3; word with i_lsb!=0.
//   WAIT_ACK: o_dbus_cyc=1 (registered; first asserted the cycle after i_req).
//             On i_dbus_ack: data <= i_dbus_rdat >> (8*lsb); o_dbus_cyc=0 next cycle;
//             o_rdy=1 next cycle; -> LOADED.
//   LOADED:   first i_en cycle -> STREAM and emits beat 0 in that same cycle.
//   STREAM:   each i_en cycle emits beat n = bits [n*BPC +: BPC], then n increments.
//             Bit k of the word: k < W -> data[k]; k >= W -> (signed ? data[W-1] : 0),
//             where W = 8/16/32 for byte/half/word.
//             After beat 32/BPC-1 the counter wraps to 0 and the FSM -> IDLE.
//             i_en low: hold; counter and o_rd frozen (o_rd=0 when i_en low, as the buffer).
//  Latency: ack -> o_rdy one cycle; o_rdy -> first beat on the first i_en.
//  Ignored events: i_req outside IDLE; i_dbus_ack outside WAIT_ACK; i_en in IDLE/WAIT_ACK.
//  Simultaneous: i_req in the final STREAM beat is ignored; the source retries after o_busy falls.
//  i_rst mid-operation: wins over everything; o_dbus_cyc drops the next edge; a late ack is ignored.
// STRUCTURE
//  Shared package/header: size encodings (SZ_B/SZ_H/SZ_W), FSM state encodings, BPC legality check.
//  One natural sub-module: serv_load_extend (combinational; beat index, size, signed, data -> o_rd).
//  FSM, counter and data register stay in the top module.
// TESTING
//  BPC=8, LW lsb=0, rdat=32'hDEADBEEF, ack after 3 cycles -> cyc held 3 cycles;
//    beats EF,BE,AD,DE.
//  LB signed, lsb=2, rdat=32'h0080_0000 -> beats 80,FF,FF,FF.
//  LBU same stimulus -> beats 80,00,00,00.
//  LH lsb=3 -> o_misalign pulse 1 cycle, o_dbus_cyc never asserted, o_busy stays 0.
//  BPC=1, LHU lsb=2, rdat=32'h8001_0000 -> 32 bits: 1,0..0,1 (bit15), then 16 zeros.
//  i_rst during WAIT_ACK, ack next cycle -> cyc=0, no o_rdy, IDLE; new LW then completes normally.

Source files
------------

// File: rtl/serv_load_unpacker_pkg.sv
// Shared definitions for the serial load unpacker.
//   - access size encodings as presented on i_size
//   - FSM state encoding (also visible on the debug state output)
//   - legality check for the serial beat width
package serv_load_unpacker_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;   // 2'd3 is reserved and decodes as a word

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_ACK = 2'd1,
        ST_LOADED   = 2'd2,
        ST_STREAM   = 2'd3
    } load_state_t;

    function automatic bit bpc_legal(input int bpc);
        return (bpc == 1) || (bpc == 4) || (bpc == 8);
    endfunction

endpackage

// File: rtl/serv_load_unpacker_if.sv
// Data-bus read channel between the load unpacker and the bus.
//   dbus_cyc   cycle request, held by the unpacker until dbus_ack
//   dbus_ack   acknowledge; dbus_rdat is valid in the same cycle
//   dbus_rdat  32-bit read word
// Handshake: the unpacker raises dbus_cyc and keeps it high; the bus completes
// the transfer by pulsing dbus_ack for exactly the cycle in which dbus_rdat is
// valid. An ack seen while dbus_cyc is low has no effect.
interface serv_load_unpacker_if;
    logic        dbus_cyc;
    logic        dbus_ack;
    logic [31:0] dbus_rdat;

    modport master (output dbus_cyc, input dbus_ack, input dbus_rdat);
    modport slave  (input dbus_cyc, output dbus_ack, output dbus_rdat);
endinterface

// File: rtl/serv_load_extend.sv
// Combinational beat selector with sign/zero extension.
//   i_beat    beat index within the 32-bit word
//   i_size    access size (byte/half/word)
//   i_signed  1 = replicate the top bit of the loaded field, 0 = fill with zeros
//   i_data    loaded word, already shifted down by the byte offset
//   o_rd      BITS_PER_CYCLE bits of word bits [i_beat*BPC +: BPC]
module serv_load_extend
    import serv_load_unpacker_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 8,
    localparam int CW = 5 - $clog2(BITS_PER_CYCLE)
) (
    input  logic [CW-1:0]             i_beat,
    input  logic [1:0]                i_size,
    input  logic                      i_signed,
    input  logic [31:0]               i_data,
    output logic [BITS_PER_CYCLE-1:0] o_rd
);

    logic [5:0] w_width;
    logic       w_fill;
    logic [5:0] w_k;

    // Field width and the bit used above it.
    always_comb begin
        w_width = 6'd32;
        w_fill  = i_signed & i_data[31];
        case (i_size)
            SZ_B: begin
                w_width = 6'd8;
                w_fill  = i_signed & i_data[7];
            end
            SZ_H: begin
                w_width = 6'd16;
                w_fill  = i_signed & i_data[15];
            end
            default: begin
                w_width = 6'd32;
                w_fill  = i_signed & i_data[31];
            end
        endcase
    end

    always_comb begin
        o_rd = '0;
        w_k  = '0;
        for (int j = 0; j < BITS_PER_CYCLE; j++) begin
            w_k     = 6'(int'(i_beat) * BITS_PER_CYCLE + j);
            o_rd[j] = (w_k < w_width) ? i_data[w_k[4:0]] : w_fill;
        end
    end

endmodule

// File: rtl/serv_load_unpacker.sv
// Load unpacker: runs one dbus read per accepted load request, captures and
// aligns the read word, then streams it back LSB first, BITS_PER_CYCLE bits
// per i_en cycle, sign- or zero-extended to 32 bits.
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_req                 load request pulse (only honoured in IDLE)
//   i_lsb/i_size/i_signed byte offset, access size, extension mode
//   dbus                  read channel (cyc out, ack/rdat in)
//   o_misalign            one-cycle pulse: request rejected (crosses a word)
//   o_rdy                 one-cycle pulse: data captured, streaming may start
//   i_en                  stream advance, one beat per high cycle
//   o_rd                  current beat; zero whenever i_en is low
//   o_busy                high outside IDLE
//   o_dbg_state           current FSM state
module serv_load_unpacker
    import serv_load_unpacker_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 8,
    localparam int LB = $clog2(BITS_PER_CYCLE)
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_req,
    input  logic [1:0]                i_lsb,
    input  logic [1:0]                i_size,
    input  logic                      i_signed,
    serv_load_unpacker_if.master      dbus,
    output logic                      o_misalign,
    output logic                      o_rdy,
    input  logic                      i_en,
    output logic [BITS_PER_CYCLE-1:0] o_rd,
    output logic                      o_busy,
    output logic [1:0]                o_dbg_state
);

    localparam int          CW       = 5 - LB;
    localparam logic [CW-1:0] CNT_LAST = '1;

    if (!bpc_legal(BITS_PER_CYCLE)) begin : g_bpc_check
        $error("serv_load_unpacker: BITS_PER_CYCLE must be 1, 4 or 8");
    end

    load_state_t r_state, w_state_nxt;
    logic          r_cyc,      w_cyc_nxt;
    logic          r_rdy,      w_rdy_nxt;
    logic          r_misalign, w_misalign_nxt;
    logic [CW-1:0] r_cnt,      w_cnt_nxt;
    logic [31:0]   r_data,     w_data_nxt;
    logic [1:0]    r_lsb;
    logic [1:0]    r_size;
    logic          r_signed;
    logic          w_capture;
    logic          w_legal;
    logic          w_streaming;
    logic [BITS_PER_CYCLE-1:0] w_beat;

    // A half may not start at offset 3; a word (or reserved size) must be aligned.
    always_comb begin
        case (i_size)
            SZ_B:    w_legal = 1'b1;
            SZ_H:    w_legal = (i_lsb != 2'd3);
            default: w_legal = (i_lsb == 2'd0);
        endcase
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cyc_nxt      = r_cyc;
        w_rdy_nxt      = 1'b0;
        w_misalign_nxt = 1'b0;
        w_cnt_nxt      = r_cnt;
        w_data_nxt     = r_data;
        w_capture      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_req) begin
                    if (w_legal) begin
                        w_state_nxt = ST_WAIT_ACK;
                        w_cyc_nxt   = 1'b1;
                        w_capture   = 1'b1;
                    end else begin
                        w_misalign_nxt = 1'b1;
                    end
                end
            end
            ST_WAIT_ACK: begin
                if (dbus.dbus_ack) begin
                    w_state_nxt = ST_LOADED;
                    w_cyc_nxt   = 1'b0;
                    w_rdy_nxt   = 1'b1;
                    w_data_nxt  = dbus.dbus_rdat >> {r_lsb, 3'b000};
                end
            end
            // LOADED emits beat 0 on its first enabled cycle, so both states
            // share the same advance rule; the counter wraps to 0 on the last beat.
            ST_LOADED, ST_STREAM: begin
                if (i_en) begin
                    w_cnt_nxt   = r_cnt + CW'(1);
                    w_state_nxt = (r_cnt == CNT_LAST) ? ST_IDLE : ST_STREAM;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_cyc      <= 1'b0;
            r_rdy      <= 1'b0;
            r_misalign <= 1'b0;
            r_cnt      <= '0;
            r_data     <= '0;
            r_lsb      <= '0;
            r_size     <= '0;
            r_signed   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cyc      <= w_cyc_nxt;
            r_rdy      <= w_rdy_nxt;
            r_misalign <= w_misalign_nxt;
            r_cnt      <= w_cnt_nxt;
            r_data     <= w_data_nxt;
            if (w_capture) begin
                r_lsb    <= i_lsb;
                r_size   <= i_size;
                r_signed <= i_signed;
            end
        end
    end

    serv_load_extend #(
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_extend (
        .i_beat   (r_cnt),
        .i_size   (r_size),
        .i_signed (r_signed),
        .i_data   (r_data),
        .o_rd     (w_beat)
    );

    assign w_streaming  = (r_state == ST_LOADED) || (r_state == ST_STREAM);
    assign o_rd         = (w_streaming && i_en) ? w_beat : '0;
    assign dbus.dbus_cyc = r_cyc;
    assign o_rdy        = r_rdy;
    assign o_misalign   = r_misalign;
    assign o_busy       = (r_state != ST_IDLE);
    assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_serv_load_unpacker.sv
// Directed bench for serv_load_unpacker: one instance at 8 bits per beat and
// one at 1 bit per beat, each with its own bus interface.
module tb_serv_load_unpacker;

    logic clk;
    logic rst;

    logic       req   [2];
    logic [1:0] lsb   [2];
    logic [1:0] size  [2];
    logic       sgn   [2];
    logic       en    [2];
    logic       mis   [2];
    logic       rdy   [2];
    logic       busy  [2];
    logic [1:0] dbg   [2];
    logic [7:0] rd8;
    logic [0:0] rd1;

    serv_load_unpacker_if bus8 ();
    serv_load_unpacker_if bus1 ();

    int n_checks;
    int n_errors;
    logic [31:0] exp_q[$];

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    serv_load_unpacker #(.BITS_PER_CYCLE(8)) u_dut8 (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req       (req[0]),
        .i_lsb       (lsb[0]),
        .i_size      (size[0]),
        .i_signed    (sgn[0]),
        .dbus        (bus8.master),
        .o_misalign  (mis[0]),
        .o_rdy       (rdy[0]),
        .i_en        (en[0]),
        .o_rd        (rd8),
        .o_busy      (busy[0]),
        .o_dbg_state (dbg[0])
    );

    serv_load_unpacker #(.BITS_PER_CYCLE(1)) u_dut1 (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req       (req[1]),
        .i_lsb       (lsb[1]),
        .i_size      (size[1]),
        .i_signed    (sgn[1]),
        .dbus        (bus1.master),
        .o_misalign  (mis[1]),
        .o_rdy       (rdy[1]),
        .i_en        (en[1]),
        .o_rd        (rd1),
        .o_busy      (busy[1]),
        .o_dbg_state (dbg[1])
    );

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] obs_rd(input int s);
        return (s == 1) ? 32'(rd1) : 32'(rd8);
    endfunction

    function automatic logic obs_cyc(input int s);
        return (s == 1) ? bus1.dbus_cyc : bus8.dbus_cyc;
    endfunction

    task automatic set_ack(input int s, input logic a, input logic [31:0] d);
        if (s == 1) begin
            bus1.dbus_ack  = a;
            bus1.dbus_rdat = d;
        end else begin
            bus8.dbus_ack  = a;
            bus8.dbus_rdat = d;
        end
    endtask

    // ---------------- driver tasks ----------------
    // Issue a load, ack it after dly cycles of cyc, check cyc length and rdy pulse.
    task automatic do_load(input int s, input logic [1:0] l, input logic [1:0] sz,
                           input logic sg, input logic [31:0] d, input int dly);
        int n_cyc;
        n_cyc = 0;
        @(negedge clk);
        req[s] = 1'b1; lsb[s] = l; size[s] = sz; sgn[s] = sg;
        for (int i = 0; i < dly; i++) begin
            @(negedge clk);
            req[s] = 1'b0;
            if (obs_cyc(s)) n_cyc++;
            if (i == dly - 1) set_ack(s, 1'b1, d);
        end
        @(negedge clk);
        set_ack(s, 1'b0, 32'h0);
        #1;
        check("cyc_len",   32'(n_cyc), 32'(dly));
        check("cyc_drop",  32'(obs_cyc(s)), 32'd0);
        check("rdy_high",  32'(rdy[s]), 32'd1);
        check("busy_load", 32'(busy[s]), 32'd1);
        @(negedge clk);
        #1;
        check("rdy_pulse", 32'(rdy[s]), 32'd0);
    endtask

    // Stream nbeats beats against exp_q; optional one-cycle en gap after beat 0,
    // optional request raised during the final beat (must be ignored).
    task automatic stream(input int s, input int nbeats, input bit gap, input bit req_last);
        int b;
        int cyc_n;
        b = 0;
        cyc_n = 0;
        while (b < nbeats && cyc_n < 4 * nbeats + 8) begin
            cyc_n++;
            @(negedge clk);
            if (gap && cyc_n == 2) begin
                en[s] = 1'b0;
                #1;
                check("gap_rd", obs_rd(s), 32'h0);
                check("gap_busy", 32'(busy[s]), 32'd1);
            end else begin
                en[s]  = 1'b1;
                req[s] = req_last && (b == nbeats - 1);
                #1;
                check("beat", obs_rd(s), exp_q.pop_front());
                b++;
            end
        end
        if (b != nbeats) check("stream_budget", 32'(b), 32'(nbeats));
        @(negedge clk);
        en[s] = 1'b0; req[s] = 1'b0;
        #1;
        check("busy_end", 32'(busy[s]), 32'd0);
        check("cyc_end",  32'(obs_cyc(s)), 32'd0);
        check("state_end", 32'(dbg[s]), 32'd0);
    endtask

    task automatic push_bytes(input logic [31:0] w);
        for (int i = 0; i < 4; i++) exp_q.push_back(32'(w[8*i +: 8]));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] w;
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        for (int s = 0; s < 2; s++) begin
            req[s] = 1'b0; lsb[s] = 2'd0; size[s] = 2'd0; sgn[s] = 1'b0; en[s] = 1'b0;
        end
        set_ack(0, 1'b0, 32'h0);
        set_ack(1, 1'b0, 32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;

        // reset state
        check("rst_cyc",   32'(bus8.dbus_cyc), 32'd0);
        check("rst_rdy",   32'(rdy[0]), 32'd0);
        check("rst_mis",   32'(mis[0]), 32'd0);
        check("rst_busy",  32'(busy[0]), 32'd0);
        check("rst_rd",    32'(rd8), 32'h0);
        check("rst_state", 32'(dbg[0]), 32'd0);
        check("rst_busy1", 32'(busy[1]), 32'd0);

        // ack and en while idle are ignored
        @(negedge clk);
        set_ack(0, 1'b1, 32'hFFFF_FFFF);
        en[0] = 1'b1;
        #1;
        check("idle_en_rd", 32'(rd8), 32'h0);
        @(negedge clk);
        set_ack(0, 1'b0, 32'h0);
        en[0] = 1'b0;
        #1;
        check("idle_ack_rdy",  32'(rdy[0]), 32'd0);
        check("idle_ack_busy", 32'(busy[0]), 32'd0);

        // LW lsb=0, ack after 3 cycles
        push_bytes(32'hDEAD_BEEF);
        do_load(0, 2'd0, 2'd2, 1'b0, 32'hDEAD_BEEF, 3);
        stream(0, 4, 1'b1, 1'b0);

        // LB signed lsb=2
        exp_q.push_back(32'h80); exp_q.push_back(32'hFF);
        exp_q.push_back(32'hFF); exp_q.push_back(32'hFF);
        do_load(0, 2'd2, 2'd0, 1'b1, 32'h0080_0000, 1);
        stream(0, 4, 1'b0, 1'b0);

        // LBU same stimulus; request during the final beat is dropped
        exp_q.push_back(32'h80); exp_q.push_back(32'h00);
        exp_q.push_back(32'h00); exp_q.push_back(32'h00);
        do_load(0, 2'd2, 2'd0, 1'b0, 32'h0080_0000, 2);
        stream(0, 4, 1'b0, 1'b1);

        // LH lsb=3: misaligned
        @(negedge clk);
        req[0] = 1'b1; lsb[0] = 2'd3; size[0] = 2'd1; sgn[0] = 1'b0;
        @(negedge clk);
        req[0] = 1'b0;
        #1;
        check("mis_pulse", 32'(mis[0]), 32'd1);
        check("mis_cyc",   32'(bus8.dbus_cyc), 32'd0);
        check("mis_busy",  32'(busy[0]), 32'd0);
        @(negedge clk);
        #1;
        check("mis_clear", 32'(mis[0]), 32'd0);
        check("mis_cyc2",  32'(bus8.dbus_cyc), 32'd0);
        check("mis_busy2", 32'(busy[0]), 32'd0);

        // LW lsb=1: misaligned word
        @(negedge clk);
        req[0] = 1'b1; lsb[0] = 2'd1; size[0] = 2'd2;
        @(negedge clk);
        req[0] = 1'b0;
        #1;
        check("misw_pulse", 32'(mis[0]), 32'd1);
        check("misw_busy",  32'(busy[0]), 32'd0);

        // BPC=1, LHU lsb=2: data 0x8001 -> bits 0 and 15 set
        w = 32'h0000_8001;
        for (int i = 0; i < 32; i++) exp_q.push_back(32'(w[i]));
        do_load(1, 2'd2, 2'd1, 1'b0, 32'h8001_0000, 2);
        stream(1, 32, 1'b0, 1'b0);

        // reset during WAIT_ACK, then a late ack
        @(negedge clk);
        req[0] = 1'b1; lsb[0] = 2'd0; size[0] = 2'd2; sgn[0] = 1'b0;
        @(negedge clk);
        req[0] = 1'b0;
        #1;
        check("wait_cyc", 32'(bus8.dbus_cyc), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        set_ack(0, 1'b1, 32'hCAFE_F00D);
        #1;
        check("rst_mid_cyc",  32'(bus8.dbus_cyc), 32'd0);
        check("rst_mid_busy", 32'(busy[0]), 32'd0);
        @(negedge clk);
        set_ack(0, 1'b0, 32'h0);
        #1;
        check("late_ack_rdy",  32'(rdy[0]), 32'd0);
        check("late_ack_busy", 32'(busy[0]), 32'd0);

        // fresh LW after the aborted one
        push_bytes(32'h1234_5678);
        do_load(0, 2'd0, 2'd2, 1'b0, 32'h1234_5678, 1);
        stream(0, 4, 1'b0, 1'b0);

        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
